// File: rtl/fetch_unit.sv
`default_nettype none
//==============================================================================
// fetch_unit - single-outstanding instruction fetcher with 2-entry prefetch FIFO
// Revision: 1.0
//==============================================================================
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_fetch_pc;
  logic [1:0]  r_count;
  logic [15:0] r_data0, r_data1;
  logic [15:0] r_pc0, r_pc1;
  logic        r_err;

  logic        w_push;
  logic        w_pop;
  logic        w_halt_pop;
  logic [1:0]  w_base;

  assign mem_addr    = r_fetch_pc;
  assign mem_rd      = !rst && (r_state == S_FETCH) && (r_count < 2'd2) && !redirect;
  assign instr       = r_data0;
  assign instr_pc    = r_pc0;
  assign instr_valid = (r_count != 2'd0);
  assign halted      = (r_state == S_HALTED);
  assign err         = r_err;

  assign w_push     = (r_state == S_WAIT) && mem_done;
  assign w_pop      = instr_valid && decode_ready;
  assign w_halt_pop = w_pop && (r_data0[15:11] == 5'b00000);
  // Slot a new word lands in once any same-cycle pop has shifted the FIFO.
  assign w_base     = r_count - {1'b0, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= 16'h0000;
      r_count    <= 2'd0;
      r_data0    <= 16'h0000;
      r_data1    <= 16'h0000;
      r_pc0      <= 16'h0000;
      r_pc1      <= 16'h0000;
      r_err      <= 1'b0;
    end else begin
      r_err <= (r_state == S_FETCH) && mem_done;
      if (r_state == S_HALTED) begin
        r_count <= 2'd0;
      end else if (w_halt_pop) begin
        r_state <= S_HALTED;
        r_count <= 2'd0;
      end else if (redirect) begin
        r_count    <= 2'd0;
        r_fetch_pc <= redirect_pc;
        if (r_state == S_WAIT)
          r_state <= mem_done ? S_FETCH : S_DRAIN;
      end else begin
        if (w_pop) begin
          r_data0 <= r_data1;
          r_pc0   <= r_pc1;
        end
        if (w_push) begin
          if (w_base == 2'd0) begin
            r_data0 <= mem_data;
            r_pc0   <= r_fetch_pc;
          end else begin
            r_data1 <= mem_data;
            r_pc1   <= r_fetch_pc;
          end
        end
        r_count <= w_base + {1'b0, w_push};
        case (r_state)
          S_FETCH: begin
            if (mem_rd && !mem_stall)
              r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (mem_done) begin
              r_state    <= S_FETCH;
              r_fetch_pc <= r_fetch_pc + 16'd2;
            end
          end
          S_DRAIN: begin
            if (mem_done)
              r_state <= S_FETCH;
          end
          default: r_state <= S_HALTED;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//==============================================================================
// tb_fetch_unit - directed self-checking bench for fetch_unit
// Revision: 1.0
//==============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready;
  logic        halted;
  logic        err;

  int checks;
  int fails;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_stall    (mem_stall),
    .mem_done     (mem_done),
    .mem_data     (mem_data),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .halted       (halted),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; mem_stall = 1'b0;
    mem_done = 1'b0; mem_data = 16'h0000; decode_ready = 1'b0;
    #1;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; mem_stall = 1'b0;
    mem_done = 1'b0; mem_data = 16'h0000; decode_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    checks++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin fails++; $display("FAIL reset_instr: got %h/%h want 0000/0000", instr, instr_pc); end
    step;
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL reset_held_mem_rd: got %b want 0", mem_rd); end
    rst = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin fails++; $display("FAIL first_request: got rd=%b addr=%h want 1/0000", mem_rd, mem_addr); end
    step;
  endtask

  task automatic test_stream;
    do_reset;
    decode_ready = 1'b1;
    #1;
    checks++; if (mem_rd !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL stream_c0: got rd=%b v=%b want 1/0", mem_rd, instr_valid); end
    step;
    mem_done = 1'b1; mem_data = 16'h4001;
    #1;
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL stream_c1_rd: got %b want 0", mem_rd); end
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h4001 || instr_pc !== 16'h0000) begin fails++; $display("FAIL stream_c2_head: got v=%b %h@%h want 1 4001@0000", instr_valid, instr, instr_pc); end
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0002) begin fails++; $display("FAIL stream_c2_req: got rd=%b addr=%h want 1/0002", mem_rd, mem_addr); end
    step;
    mem_done = 1'b1; mem_data = 16'h4002;
    #1;
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stream_c3_valid: got %b want 0", instr_valid); end
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h4002 || instr_pc !== 16'h0002) begin fails++; $display("FAIL stream_c4_head: got v=%b %h@%h want 1 4002@0002", instr_valid, instr, instr_pc); end
    step;
  endtask

  task automatic test_stall;
    do_reset;
    decode_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0004;
    step;
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_stall = (k < 3);
      #1;
      checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0004) begin fails++; $display("FAIL stall_hold_%0d: got rd=%b addr=%h want 1/0004", k, mem_rd, mem_addr); end
      step;
    end
    mem_done = 1'b1; mem_data = 16'h4003;
    #1;
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL stall_wait_rd: got %b want 0", mem_rd); end
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h4003 || instr_pc !== 16'h0004 || mem_addr !== 16'h0006) begin fails++; $display("FAIL stall_push: got v=%b %h@%h addr=%h want 1 4003@0004 0006", instr_valid, instr, instr_pc, mem_addr); end
    step;
    #1;
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stall_single_push: got valid=%b want 0", instr_valid); end
  endtask

  task automatic test_backpressure;
    do_reset;
    step;
    mem_done = 1'b1; mem_data = 16'h4001;
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0002) begin fails++; $display("FAIL bp_second_req: got rd=%b addr=%h want 1/0002", mem_rd, mem_addr); end
    step;
    mem_done = 1'b1; mem_data = 16'h4002;
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin fails++; $display("FAIL bp_full: got rd=%b v=%b pc=%h want 0/1/0000", mem_rd, instr_valid, instr_pc); end
    step;
    #1;
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL bp_full_hold: got rd=%b want 0", mem_rd); end
    decode_ready = 1'b1;
    step;
    decode_ready = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0004) begin fails++; $display("FAIL bp_resume: got rd=%b addr=%h want 1/0004", mem_rd, mem_addr); end
    checks++; if (instr !== 16'h4002 || instr_pc !== 16'h0002) begin fails++; $display("FAIL bp_head: got %h@%h want 4002@0002", instr, instr_pc); end
  endtask

  task automatic test_redirect;
    do_reset;
    decode_ready = 1'b1;
    step;
    redirect = 1'b1; redirect_pc = 16'h0100;
    #1;
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL redir_rd_blocked: got %b want 0", mem_rd); end
    step;
    redirect = 1'b0; mem_done = 1'b1; mem_data = 16'h4055;
    #1;
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL redir_drain_rd: got %b want 0", mem_rd); end
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL redir_discard: got v=%b err=%b want 0/0", instr_valid, err); end
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0100) begin fails++; $display("FAIL redir_target: got rd=%b addr=%h want 1/0100", mem_rd, mem_addr); end
    step;
    mem_done = 1'b1; mem_data = 16'h4066; redirect = 1'b1; redirect_pc = 16'h0200;
    step;
    mem_done = 1'b0; redirect = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0200) begin fails++; $display("FAIL redir_same_cycle: got v=%b rd=%b addr=%h want 0/1/0200", instr_valid, mem_rd, mem_addr); end
  endtask

  task automatic test_halt;
    do_reset;
    decode_ready = 1'b1;
    step;
    mem_done = 1'b1; mem_data = 16'h0000;
    step;
    mem_done = 1'b0; redirect = 1'b1; redirect_pc = 16'h0300;
    step;
    redirect = 1'b0;
    #1;
    checks++; if (halted !== 1'b1 || mem_rd !== 1'b0 || instr_valid !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL halt_enter: got h=%b rd=%b v=%b err=%b want 1/0/0/0", halted, mem_rd, instr_valid, err); end
    checks++; if (mem_addr !== 16'h0002) begin fails++; $display("FAIL halt_redirect_ignored: got addr=%h want 0002", mem_addr); end
    for (int k = 0; k < 3; k++) begin
      redirect = 1'b1; redirect_pc = 16'h0400; mem_done = 1'b1; mem_data = 16'h4000;
      step;
      #1;
      checks++; if (halted !== 1'b1 || mem_rd !== 1'b0 || err !== 1'b0 || mem_addr !== 16'h0002) begin fails++; $display("FAIL halt_hold_%0d: got h=%b rd=%b err=%b addr=%h want 1/0/0/0002", k, halted, mem_rd, err, mem_addr); end
    end
    redirect = 1'b0; mem_done = 1'b0;
  endtask

  task automatic test_halt_in_wait;
    do_reset;
    step;
    mem_done = 1'b1; mem_data = 16'h07FF;
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b1 || instr !== 16'h07FF) begin fails++; $display("FAIL hw_req: got rd=%b instr=%h want 1/07FF", mem_rd, instr); end
    step;
    decode_ready = 1'b1;
    step;
    decode_ready = 1'b0; mem_done = 1'b1; mem_data = 16'h4000;
    #1;
    checks++; if (halted !== 1'b1 || mem_rd !== 1'b0) begin fails++; $display("FAIL hw_halted: got h=%b rd=%b want 1/0", halted, mem_rd); end
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (err !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL hw_late_done: got err=%b v=%b want 0/0", err, instr_valid); end
  endtask

  task automatic test_wrap_err;
    do_reset;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step;
    redirect = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFE) begin fails++; $display("FAIL wrap_req: got rd=%b addr=%h want 1/FFFE", mem_rd, mem_addr); end
    step;
    mem_done = 1'b1; mem_data = 16'h4010;
    step;
    mem_stall = 1'b1;
    #1;
    checks++; if (mem_addr !== 16'h0000 || instr_pc !== 16'hFFFE || instr_valid !== 1'b1) begin fails++; $display("FAIL wrap_pc: got addr=%h pc=%h v=%b want 0000/FFFE/1", mem_addr, instr_pc, instr_valid); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_before: got %b want 0", err); end
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b want 1", err); end
    step;
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_one_cycle: got %b want 0", err); end
    mem_stall = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    do_reset;
    step;
    rst = 1'b1;
    #1;
    checks++; if (mem_rd !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL rmw_in_reset: got rd=%b v=%b want 0/0", mem_rd, instr_valid); end
    step;
    rst = 1'b0; mem_done = 1'b1; mem_data = 16'h4321;
    #1;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin fails++; $display("FAIL rmw_reissue: got rd=%b addr=%h want 1/0000", mem_rd, mem_addr); end
    step;
    mem_done = 1'b0;
    #1;
    checks++; if (err !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL rmw_err: got err=%b v=%b want 1/0", err, instr_valid); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset;
    test_stream;
    test_stall;
    test_backpressure;
    test_redirect;
    test_halt;
    test_halt_in_wait;
    test_wrap_err;
    test_reset_mid_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  branch/jump taken this cycle.
- redirect_pc  in  16  new fetch address, valid when redirect=1.
- mem_addr  out  16  instruction memory read address.
- mem_rd  out  1  read request.
- mem_stall  in  1  memory refuses the request this cycle.
- mem_done  in  1  read data valid this cycle.
- mem_data  in  16  instruction word.
- instr  out  16  head instruction to decode.
- instr_pc  out  16  address of head instruction.
- instr_valid  out  1  head entry present.
- decode_ready  in  1  decode consumes head this cycle.
- halted  out  1  HALT has been consumed.
- err  out  1  one-cycle pulse on an unexpected mem_done.

Function
REQ-002 The block SHALL hold a 16-bit fetch_pc, a 2-entry FIFO of {instr, pc} pairs with a 2-bit count, and a state in {FETCH, WAIT, DRAIN, HALTED}.
REQ-003 mem_rd SHALL be 1 iff state=FETCH, count<2 and redirect=0; mem_addr SHALL equal fetch_pc at all times.
REQ-004 A request SHALL be accepted when mem_rd=1 and mem_stall=0: the state moves FETCH->WAIT; with mem_stall=1 the state stays FETCH and the same address is re-presented the next cycle.
REQ-005 In WAIT, mem_done=1 SHALL do all of the following:
- push {mem_data, fetch_pc} into the FIFO;
- set fetch_pc to fetch_pc+2, with modulo-2^16 wrap (0xFFFE -> 0x0000);
- return to FETCH.
REQ-006 At most one request SHALL be outstanding; the next mem_rd SHALL be asserted no earlier than the cycle after mem_done.
REQ-007 instr/instr_pc SHALL present the FIFO head; instr_valid=(count!=0); a pop SHALL occur when instr_valid=1 and decode_ready=1.
REQ-008 Simultaneous push and pop SHALL leave count unchanged. The FIFO SHALL never overflow: issue requires count<2, and only one request is ever outstanding.
REQ-009 A pushed word SHALL appear on instr with instr_valid=1 the cycle after its mem_done (one-cycle latency).
REQ-010 redirect=1 (state not HALTED) SHALL:
- flush the FIFO (count=0);
- load fetch_pc<=redirect_pc;
- override any same-cycle push and pop.
REQ-011 redirect in WAIT without mem_done SHALL move to DRAIN. DRAIN SHALL discard the next mem_done without a push and without a fetch_pc change, then go to FETCH.
REQ-012 redirect in WAIT with mem_done in the same cycle SHALL discard that data and go directly to FETCH.
REQ-013 A further redirect in DRAIN SHALL update fetch_pc only; the state remains DRAIN.
REQ-014 Popping an instruction with instr[15:11]=5'b00000 (HALT) SHALL move to HALTED.
- In HALTED: flush the FIFO; mem_rd=0, instr_valid=0, halted=1 until reset.
- HALT pop SHALL take priority over a same-cycle redirect.
REQ-015 HALT popped while WAIT/DRAIN SHALL still enter HALTED; the late mem_done SHALL be ignored without err.
REQ-016 err SHALL pulse for one cycle when mem_done=1 in FETCH.

Reset
REQ-017 While rst=1, the block SHALL force the following asynchronously:
- state=FETCH, fetch_pc=0x0000, count=0;
- mem_rd=0, instr_valid=0, halted=0, err=0, instr=0x0000, instr_pc=0x0000.
REQ-018 Reset mid-WAIT SHALL abandon the request; a mem_done in the first cycle after reset release SHALL raise err and SHALL NOT be pushed.
REQ-019 The first request SHALL be issued (mem_rd=1, mem_addr=0x0000) in the first cycle after rst deasserts.

Verification
REQ-020 Streaming: single-cycle memory, decode_ready=1, words 0x4001,0x4002 -> instr_valid cycles 2 and 4 with instr_pc 0x0000 then 0x0002.
REQ-021 Stall: mem_stall=1 for 3 cycles at pc 0x0004 -> mem_rd held with mem_addr=0x0004 for 4 cycles; one push only.
REQ-022 Backpressure: decode_ready=0, two words fetched -> count=2, mem_rd=0. Pop one -> mem_rd=1 next cycle at pc 0x0004.
REQ-023 Redirect in WAIT to 0x0100 -> next mem_done is discarded (instr_valid stays 0); the next mem_rd has mem_addr=0x0100.
REQ-024 HALT: word 0x0000 popped with simultaneous redirect -> halted=1 next cycle, mem_rd=0 forever, redirect ignored, err=0.
REQ-025 Wrap and error: fetch_pc=0xFFFE fetch -> next mem_addr=0x0000; spurious mem_done in FETCH -> err=1 for exactly one cycle.
